// File: rtl/stopwatch_ctrl.sv
// Stopwatch core: synchronizes the divider square wave and the buttons, runs a
// start/stop/lap/clear FSM and keeps a four-digit BCD mm:ss count with lap snapshot.
module stopwatch_ctrl #(
  parameter int unsigned TICKS_PER_COUNT = 1
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       tick_in,
  input  logic       btn_ss,
  input  logic       btn_lap,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       lap_active
);

  localparam logic [15:0] PrescMax = 16'(TICKS_PER_COUNT - 1);

  typedef enum logic [1:0] {StIdle, StRun, StPaused, StLap} state_e;

  // Bit order in the conditioning vectors: {btn_lap, btn_ss, tick_in}
  logic [2:0]  r_sync1, r_sync2, r_prev, r_pulse;
  logic        w_tick_p, w_ss_p, w_lap_p;

  state_e      r_state, w_state_next;
  logic        w_capture, w_clear, w_count_en, w_advance;

  // Count and snapshot packed as {min_tens, min_ones, sec_tens, sec_ones}
  logic [15:0] r_count, w_count_next;
  logic [15:0] r_snap;
  logic [15:0] r_presc, w_presc_next;
  logic [15:0] r_disp;
  logic        r_running, r_lap_active;

  // Two-flop synchronizers followed by a registered rising-edge detector
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
      r_prev  <= 3'b000;
      r_pulse <= 3'b000;
    end else begin
      r_sync1 <= {btn_lap, btn_ss, tick_in};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_pulse <= r_sync2 & ~r_prev;
    end
  end

  assign w_tick_p = r_pulse[0];
  assign w_ss_p   = r_pulse[1];
  assign w_lap_p  = r_pulse[2];

  // FSM state register
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  // FSM next state; start/stop takes priority over lap when both pulse together
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_clear      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_ss_p) w_state_next = StRun;
      end
      StRun: begin
        if (w_ss_p) begin
          w_state_next = StPaused;
        end else if (w_lap_p) begin
          w_state_next = StLap;
          w_capture    = 1'b1;
        end
      end
      StLap: begin
        if (w_ss_p)       w_state_next = StPaused;
        else if (w_lap_p) w_state_next = StRun;
      end
      StPaused: begin
        if (w_ss_p) begin
          w_state_next = StRun;
        end else if (w_lap_p) begin
          w_state_next = StIdle;
          w_clear      = 1'b1;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Counting follows the registered state, so a tick alongside a stop still counts
  assign w_count_en = (r_state == StRun) || (r_state == StLap);
  assign w_advance  = w_count_en && w_tick_p && (r_presc == PrescMax);

  // Prescaler and BCD carry chain next-state
  always_comb begin
    w_presc_next = r_presc;
    w_count_next = r_count;
    if (w_clear) begin
      w_presc_next = 16'd0;
      w_count_next = 16'd0;
    end else begin
      if (w_count_en && w_tick_p) begin
        w_presc_next = (r_presc == PrescMax) ? 16'd0 : r_presc + 16'd1;
      end
      if (w_advance) begin
        if (r_count[3:0] != 4'd9) begin
          w_count_next[3:0] = r_count[3:0] + 4'd1;
        end else begin
          w_count_next[3:0] = 4'd0;
          if (r_count[7:4] != 4'd5) begin
            w_count_next[7:4] = r_count[7:4] + 4'd1;
          end else begin
            w_count_next[7:4] = 4'd0;
            if (r_count[11:8] != 4'd9) begin
              w_count_next[11:8] = r_count[11:8] + 4'd1;
            end else begin
              w_count_next[11:8] = 4'd0;
              w_count_next[15:12] = (r_count[15:12] != 4'd5) ? r_count[15:12] + 4'd1 : 4'd0;
            end
          end
        end
      end
    end
  end

  // Count, prescaler and lap snapshot registers
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 16'd0;
      r_presc <= 16'd0;
      r_snap  <= 16'd0;
    end else begin
      r_count <= w_count_next;
      r_presc <= w_presc_next;
      if (w_clear)        r_snap <= 16'd0;
      else if (w_capture) r_snap <= r_count;
    end
  end

  // Registered outputs: snapshot shown only while in lap mode
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_disp       <= 16'd0;
      r_running    <= 1'b0;
      r_lap_active <= 1'b0;
    end else begin
      r_disp       <= (r_state == StLap) ? r_snap : r_count;
      r_running    <= (r_state == StRun) || (r_state == StLap);
      r_lap_active <= (r_state == StLap);
    end
  end

  assign sec_ones   = r_disp[3:0];
  assign sec_tens   = r_disp[7:4];
  assign min_ones   = r_disp[11:8];
  assign min_tens   = r_disp[15:12];
  assign running    = r_running;
  assign lap_active = r_lap_active;

endmodule
